sr_latch_driver: RTL and testbench

//   Drives the set/reset inputs of an external NOR-based SR latch from a

---
 rtl/sr_latch_driver.sv | 124 ++++++++++++
 tb/tb_sr_latch_driver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// Drives the set/reset inputs of an external NOR SR latch with fixed-width,
// mutually exclusive pulses, then confirms the stored level via a synchronized readback.
module sr_latch_driver #(
  parameter int PULSE_W = 3,
  parameter int GUARD_W = 2,
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  output logic set_o,
  output logic reset_o,
  input  logic q_i,
  output logic q_sync,
  output logic done,
  output logic err
);

  localparam int MAX_PG = (PULSE_W > GUARD_W) ? PULSE_W : GUARD_W;
  localparam int MAX_W  = (MAX_PG > TIMEOUT) ? MAX_PG : TIMEOUT;
  localparam int CW     = $clog2(MAX_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GUARD,
    CHECK
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          level, level_d;
  logic          set_d, reset_d, done_d, err_d;
  logic          q_meta;

  // q_i is asynchronous to clk, so it passes through two flops before use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_meta <= 1'b0;
      q_sync <= 1'b0;
    end else begin
      q_meta <= q_i;
      q_sync <= q_meta;
    end
  end

  // NOTE: every control register is cleared by the async reset so the latch
  // pulses drop the instant rst_n falls; sequential state uses <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      level   <= 1'b0;
      set_o   <= 1'b0;
      reset_o <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      level   <= level_d;
      set_o   <= set_d;
      reset_o <= reset_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    level_d = level;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_d = PULSE;
          level_d = req_level;
          cnt_d   = CW'(PULSE_W - 1);
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_d = GUARD;
          cnt_d   = CW'(GUARD_W - 1);
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      GUARD: begin
        if (cnt == '0) begin
          state_d = CHECK;
          cnt_d   = CW'(TIMEOUT - 1);
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      CHECK: begin
        if (q_sync == level) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pulse outputs are registered from the next state, so they align with
  // the PULSE cycles and can never be high together.
  assign set_d     = (state_d == PULSE) && level_d;
  assign reset_d   = (state_d == PULSE) && !level_d;
  assign req_ready = (state == IDLE);

endmodule

// File: tb/tb_sr_latch_driver.sv
// Randomized self-checking bench for sr_latch_driver with a behavioural NOR latch
// and a per-request timing model derived from pulse/guard/timeout widths.
module tb_sr_latch_driver;

  localparam int PULSE_W  = 3;
  localparam int GUARD_W  = 2;
  localparam int TIMEOUT  = 8;
  localparam int CHECK_AT = 1 + PULSE_W + GUARD_W;

  typedef enum int {Q_LATCH, Q_STUCK0, Q_STUCK1, Q_UNKNOWN} q_mode_t;

  logic    clk       = 1'b0;
  logic    rst_n     = 1'b1;
  logic    req_valid = 1'b0;
  logic    req_level = 1'b0;
  logic    q_i;
  logic    req_ready, set_o, reset_o, q_sync, done, err;
  logic    latch_q   = 1'b0;
  q_mode_t q_mode    = Q_UNKNOWN;
  int      errors    = 0;
  int      checks    = 0;

  sr_latch_driver #(
    .PULSE_W(PULSE_W),
    .GUARD_W(GUARD_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_level (req_level),
    .req_ready (req_ready),
    .set_o     (set_o),
    .reset_o   (reset_o),
    .q_i       (q_i),
    .q_sync    (q_sync),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Behavioural latch: settles 1 ns after its inputs change.
  always begin
    @(set_o or reset_o);
    #1;
    if (set_o && !reset_o)      latch_q = 1'b1;
    else if (reset_o && !set_o) latch_q = 1'b0;
  end

  always_comb begin
    q_i = 1'bx;
    case (q_mode)
      Q_LATCH:  q_i = latch_q;
      Q_STUCK0: q_i = 1'b0;
      Q_STUCK1: q_i = 1'b1;
      default:  q_i = 1'bx;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  always @(negedge clk) check("set_and_reset_exclusive", {31'd0, set_o & reset_o}, 32'd0);

  function automatic bit model_err(input bit level, input q_mode_t m);
    if (m == Q_STUCK0) return level;
    if (m == Q_STUCK1) return !level;
    return 1'b0;
  endfunction

  function automatic bit model_q(input bit level, input q_mode_t m);
    if (m == Q_STUCK0) return 1'b0;
    if (m == Q_STUCK1) return 1'b1;
    return level;
  endfunction

  // Called at a negedge while the DUT is idle; returns at the negedge of the done cycle.
  task automatic run_req(input bit level, input q_mode_t m, input bit hold);
    bit e;
    int lat;
    e   = model_err(level, m);
    lat = e ? CHECK_AT + TIMEOUT : CHECK_AT + 1;
    q_mode    = m;
    req_level = level;
    req_valid = 1'b1;
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (hold) req_level = !level;
    else      req_valid = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      check("set_o",     {31'd0, set_o},     {31'd0, (c <= PULSE_W) && level});
      check("reset_o",   {31'd0, reset_o},   {31'd0, (c <= PULSE_W) && !level});
      check("done",      {31'd0, done},      {31'd0, c == lat});
      check("err",       {31'd0, err},       {31'd0, (c == lat) && e});
      check("req_ready", {31'd0, req_ready}, {31'd0, c == lat});
    end
    check("q_sync_at_done", {31'd0, q_sync}, {31'd0, model_q(level, m)});
    check("latch_q_after", {31'd0, latch_q}, {31'd0, level});
  endtask

  task automatic idle_cycles(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_done",  {31'd0, done},            32'd0);
      check("idle_ready", {31'd0, req_ready},       32'd1);
      check("idle_pulse", {30'd0, set_o, reset_o},  32'd0);
    end
  endtask

  initial begin
    // Reset with an unknown latch output.
    #2 rst_n = 1'b0;
    #1;
    check("rst_set_o",   {31'd0, set_o},     32'd0);
    check("rst_reset_o", {31'd0, reset_o},   32'd0);
    check("rst_done",    {31'd0, done},      32'd0);
    check("rst_err",     {31'd0, err},       32'd0);
    check("rst_ready",   {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("rst_q_sync",  {31'd0, q_sync},    32'd0);
    check("rst_ready_held", {31'd0, req_ready}, 32'd1);
    rst_n  = 1'b1;
    q_mode = Q_LATCH;
    idle_cycles(2);

    run_req(1'b1, Q_LATCH, 1'b0);   // set
    run_req(1'b0, Q_LATCH, 1'b0);   // reset from q=1
    run_req(1'b1, Q_STUCK0, 1'b0);  // stuck latch -> timeout
    idle_cycles(1);

    // Reset in the middle of the set pulse.
    q_mode    = Q_LATCH;
    req_level = 1'b1;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("mid_set_o_before", {31'd0, set_o}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_set_o_dropped", {31'd0, set_o},     32'd0);
    check("mid_ready",         {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_no_done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    check("mid_latch_kept", {31'd0, latch_q}, 32'd1);
    run_req(1'b0, Q_LATCH, 1'b0);

    // Valid held through a busy request; the next one lands on the done cycle.
    run_req(1'b1, Q_LATCH, 1'b1);
    run_req(1'b0, Q_LATCH, 1'b0);
    idle_cycles(1);

    for (int k = 0; k < 40; k++) begin
      int      r;
      q_mode_t m;
      r = $urandom_range(0, 5);
      m = (r == 0) ? Q_STUCK0 : (r == 1) ? Q_STUCK1 : Q_LATCH;
      run_req(1'($urandom_range(0, 1)), m, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
